// File: rtl/bcd_comparator_4digits.sv
// bcd_comparator_4digits
// Registered magnitude comparator for two 4-digit packed-BCD operands.
// The digits are scanned from the most significant down, and the first digit
// pair that differs decides the result. Any nibble above 9 raises bcd_err. The
// compare still runs on the raw nibble values, so the result stays
// deterministic when bcd_err is set.

module bcd_comparator_4digits (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        out_valid,
  output logic        a_ge_b,
  output logic        a_gt_b,
  output logic        a_eq_b,
  output logic        bcd_err
);

  logic [3:0] a_dig [4];
  logic [3:0] b_dig [4];
  logic       gt_next;
  logic       eq_next;
  logic       err_next;
  logic       decided;

  // split both operands into their four digits
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      a_dig[i] = a[i*4 +: 4];
      b_dig[i] = b[i*4 +: 4];
    end
  end

  // MSD-first scan: the first differing digit pair fixes gt; no difference means eq
  always_comb begin
    gt_next = 1'b0;
    decided = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      if (!decided && (a_dig[i] != b_dig[i])) begin
        gt_next = (a_dig[i] > b_dig[i]);
        decided = 1'b1;
      end
    end
    eq_next = ~decided;
  end

  // flag any nibble in the range 0xA..0xF on either operand
  always_comb begin
    err_next = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if ((a_dig[i] > 4'd9) || (b_dig[i] > 4'd9)) begin
        err_next = 1'b1;
      end
    end
  end

  // result registers: reset clears everything; idle cycles drop out_valid and hold results
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      a_ge_b    <= 1'b0;
      a_gt_b    <= 1'b0;
      a_eq_b    <= 1'b0;
      bcd_err   <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        a_gt_b  <= gt_next;
        a_eq_b  <= eq_next;
        a_ge_b  <= gt_next | eq_next;
        bcd_err <= err_next;
      end
    end
  end

endmodule

// File: tb/tb_bcd_comparator_4digits.sv
// tb_bcd_comparator_4digits
// Scoreboard bench. The driver pushes the expected results into a queue, and
// a monitor pops and compares an entry each time out_valid is seen. The
// reference compares the whole packed words numerically. Comparing nibbles
// MSD-first is the same as an unsigned compare of the 16-bit words.

module tb_bcd_comparator_4digits;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic        a_ge_b;
  logic        a_gt_b;
  logic        a_eq_b;
  logic        bcd_err;

  typedef struct packed {
    logic ge;
    logic gt;
    logic eq;
    logic err;
  } res_t;

  res_t exp_q[$];
  res_t held;
  res_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  bcd_comparator_4digits dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .a_ge_b    (a_ge_b),
    .a_gt_b    (a_gt_b),
    .a_eq_b    (a_eq_b),
    .bcd_err   (bcd_err)
  );

  always #5 clk = ~clk;

  function automatic res_t model(input logic [15:0] x, input logic [15:0] y);
    res_t r;
    int   xv;
    int   yv;
    xv    = int'(x);
    yv    = int'(y);
    r.gt  = (xv > yv);
    r.eq  = (xv == yv);
    r.ge  = (xv >= yv);
    r.err = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (((x >> (4 * k)) & 16'hF) > 16'd9) r.err = 1'b1;
      if (((y >> (4 * k)) & 16'hF) > 16'd9) r.err = 1'b1;
    end
    return r;
  endfunction

  function automatic logic [15:0] rand_bcd();
    logic [15:0] v;
    v = '0;
    for (int k = 0; k < 4; k++) begin
      v = (v << 4) | 16'($urandom_range(0, 9));
    end
    return v;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (a=%h b=%h)", name, act, exp, a, b);
    end
  endtask

  // monitor: whenever the DUT presents a result, compare it with the oldest expectation
  always @(posedge clk) begin
    #1;
    if (out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_out_valid: got out_valid=1 expected no pending result");
      end else begin
        mon_e = exp_q.pop_front();
        check("result", {4'b0, a_ge_b, a_gt_b, a_eq_b, bcd_err}, {4'b0, mon_e});
      end
    end
  end

  // drive one cycle. The result itself is checked by the monitor; this task
  // checks reset clearing, out_valid, and holding of results on idle cycles.
  task automatic step(input logic r, input logic iv, input logic [15:0] x, input logic [15:0] y);
    rst      = r;
    in_valid = iv;
    a        = x;
    b        = y;
    if (r) begin
      held = '0;
    end else if (iv) begin
      exp_q.push_back(model(x, y));
      held = model(x, y);
    end
    @(posedge clk);
    #2;
    if (r)
      check("reset_outputs", {3'b0, out_valid, a_ge_b, a_gt_b, a_eq_b, bcd_err}, 8'b0);
    else if (!iv)
      check("idle_hold", {3'b0, out_valid, a_ge_b, a_gt_b, a_eq_b, bcd_err}, {3'b0, 1'b0, held});
    else
      check("out_valid", {7'b0, out_valid}, 8'b1);
  endtask

  // directed vector with a hand-written expectation {ge, gt, eq, err}
  task automatic spec_vec(input string name, input logic [15:0] x, input logic [15:0] y,
                          input logic [3:0] exp_bits);
    step(1'b0, 1'b1, x, y);
    check(name, {4'b0, a_ge_b, a_gt_b, a_eq_b, bcd_err}, {4'b0, exp_bits});
  endtask

  initial begin
    logic [15:0] x;
    logic [15:0] y;
    int          mode;
    int          dig;

    rst      = 1'b1;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    held     = '0;

    step(1'b1, 1'b0, 16'h0, 16'h0);
    step(1'b1, 1'b0, 16'h0, 16'h0);
    step(1'b0, 1'b0, 16'h0, 16'h0);

    spec_vec("gt_lsd",      16'h1234, 16'h1233, 4'b1100);
    spec_vec("lt_lsd",      16'h1232, 16'h1233, 4'b0000);
    spec_vec("lt_extreme",  16'h0000, 16'h9999, 4'b0000);
    spec_vec("eq_5678",     16'h5678, 16'h5678, 4'b1010);
    spec_vec("eq_zero",     16'h0000, 16'h0000, 4'b1010);
    spec_vec("gt_msd",      16'h9000, 16'h8000, 4'b1100);
    spec_vec("gt_1001",     16'h1001, 16'h1000, 4'b1100);
    spec_vec("lt_0999",     16'h0999, 16'h1000, 4'b0000);
    spec_vec("err_gt",      16'h12A4, 16'h1299, 4'b1101);
    step(1'b0, 1'b0, 16'h0000, 16'h0000);
    step(1'b0, 1'b0, 16'h1111, 16'h2222);
    step(1'b1, 1'b1, 16'h9999, 16'h0000);
    step(1'b0, 1'b0, 16'h0000, 16'h0000);
    spec_vec("resume",      16'h4321, 16'h4321, 4'b1010);

    for (int it = 0; it < 400; it++) begin
      mode = $urandom_range(0, 3);
      x    = rand_bcd();
      case (mode)
        0: y = rand_bcd();
        1: y = x;
        2: begin
          dig = $urandom_range(0, 3);
          y   = x;
          y[dig*4 +: 4] = 4'($urandom_range(0, 9));
        end
        default: begin
          x = 16'($urandom());
          y = 16'($urandom());
        end
      endcase
      step(($urandom_range(0, 24) == 0), ($urandom_range(0, 3) != 0), x, y);
    end

    step(1'b0, 1'b0, 16'h0, 16'h0);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
